// File: rtl/i2d_wb_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2d_wb_ram                                                   |
// | Description : Wishbone classic-cycle slave in front of a word-addressed    |
// |               32-bit on-chip RAM. It can insert wait states, answers       |
// |               illegal accesses with err_o, and answers with rty_o while    |
// |               hold is high.                                                |
// | Ports       : clk, rst (async, active-low)                                 |
// |               adr_i/dat_i/sel_i/we_i/cyc_i/stb_i : master request          |
// |               dat_o/ack_o/err_o/rty_o            : slave response          |
// |               hold : answer new requests with a retry                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module i2d_wb_ram #(
  parameter int          AW          = 12,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  input  logic        hold
);

  localparam int         c_DEPTH   = 1 << AW;
  localparam logic [3:0] c_WS      = 4'(WAIT_STATES);
  localparam logic [1:0] c_CLS_OK  = 2'd0;
  localparam logic [1:0] c_CLS_ERR = 2'd1;
  localparam logic [1:0] c_CLS_RTY = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_next_state;
  logic [3:0]   r_cnt;
  logic [AW-1:0] r_idx;
  logic [31:0]  r_dat;
  logic [3:0]   r_sel;
  logic         r_we;
  logic [1:0]   r_cls;
  logic         r_ack;
  logic         r_err;
  logic         r_rty;
  logic [31:0]  r_dat_o;
  logic [31:0]  r_mem [0:c_DEPTH-1];

  logic          w_req;
  logic          w_term_active;
  logic          w_in_window;
  logic          w_illegal;
  logic [1:0]    w_cls;
  logic          w_sample;
  logic          w_from_idle;
  logic [AW-1:0] w_acc_idx;
  logic [31:0]   w_acc_dat;
  logic [3:0]    w_acc_sel;
  logic          w_acc_we;
  logic [1:0]    w_acc_cls;
  logic          w_enter_resp;
  logic          w_do_write;
  logic          w_do_read;

  assign w_req         = cyc_i & stb_i;
  assign w_term_active = r_ack | r_err | r_rty;

  // BASE is aligned to the window size, so the window test is a compare of
  // the address bits above the word index.
  assign w_in_window = (adr_i[31:AW+2] == BASE[31:AW+2]);
  assign w_illegal   = !w_in_window || (adr_i[1:0] != 2'b00) || (sel_i == 4'b0000);
  assign w_cls       = hold ? c_CLS_RTY : (w_illegal ? c_CLS_ERR : c_CLS_OK);

  // The termination flop trails the RESP state by one cycle, so the cycle in
  // which the master sees ack/err/rty is spent in IDLE. The still-asserted
  // request must not be taken as a new transfer during that cycle.
  assign w_sample = (r_state == ST_IDLE) && w_req && !w_term_active;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_sample) begin
          w_next_state = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (!w_req) begin
          w_next_state = ST_IDLE;
        end else if (r_cnt == 4'd1) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // With no wait states RESP is entered straight from IDLE, before the
  // request fields have been latched, so the live bus is used in that case.
  assign w_from_idle  = (r_state == ST_IDLE);
  assign w_acc_idx    = w_from_idle ? adr_i[AW+1:2] : r_idx;
  assign w_acc_dat    = w_from_idle ? dat_i : r_dat;
  assign w_acc_sel    = w_from_idle ? sel_i : r_sel;
  assign w_acc_we     = w_from_idle ? we_i  : r_we;
  assign w_acc_cls    = w_from_idle ? w_cls : r_cls;
  assign w_enter_resp = (w_next_state == ST_RESP);
  assign w_do_write   = rst && w_enter_resp && (w_acc_cls == c_CLS_OK) && w_acc_we;
  assign w_do_read    = w_enter_resp && (w_acc_cls == c_CLS_OK) && !w_acc_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_dat   <= 32'd0;
      r_sel   <= 4'd0;
      r_we    <= 1'b0;
      r_cls   <= c_CLS_OK;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rty   <= 1'b0;
      r_dat_o <= 32'd0;
    end else begin
      r_state <= w_next_state;
      r_ack   <= (r_state == ST_RESP) && (r_cls == c_CLS_OK);
      r_err   <= (r_state == ST_RESP) && (r_cls == c_CLS_ERR);
      r_rty   <= (r_state == ST_RESP) && (r_cls == c_CLS_RTY);
      if (w_sample) begin
        r_idx <= adr_i[AW+1:2];
        r_dat <= dat_i;
        r_sel <= sel_i;
        r_we  <= we_i;
        r_cls <= w_cls;
        r_cnt <= c_WS;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_do_read) begin
        r_dat_o <= r_mem[w_acc_idx];
      end
    end
  end

  // RAM array: no reset, byte-lane write enables.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc_sel[i]) begin
          r_mem[w_acc_idx][8*i +: 8] <= w_acc_dat[8*i +: 8];
        end
      end
    end
  end

  assign dat_o = r_dat_o;
  assign ack_o = r_ack;
  assign err_o = r_err;
  assign rty_o = r_rty;

endmodule
`default_nettype wire
